// File: rtl/entity_frame_buffer_pkg.sv
// entity_frame_buffer_pkg: shared record layout, slot count, swap line and FSM encodings
package entity_frame_buffer_pkg;
  localparam int ENTITY_W = 20;
  localparam int NUM_SLOTS = 15;
  localparam int OUT_W = NUM_SLOTS * ENTITY_W;
  localparam logic [9:0] V_SWAP = 10'd480;
  localparam int SPRITE_HI = 19;
  localparam int SPRITE_LO = 16;
  localparam int ORIENT_HI = 15;
  localparam int ORIENT_LO = 14;
  localparam int TILE_X_HI = 13;
  localparam int TILE_X_LO = 9;
  localparam int TILE_Y_HI = 8;
  localparam int TILE_Y_LO = 4;
  localparam int LEN_HI = 3;
  localparam int LEN_LO = 0;
  localparam logic [ENTITY_W-1:0] EMPTY = 20'hF0000;
  typedef enum logic [1:0] {ACCEPT = 2'd0, CLEAR = 2'd1, WAIT = 2'd2} state_t;
endpackage

// File: rtl/entity_frame_buffer_if.sv
// entity_frame_buffer_if: game-logic write/commit/clear bus; master = producer, slave = frame buffer
interface entity_frame_buffer_if;
  import entity_frame_buffer_pkg::*;
  logic wr_valid;
  logic [3:0] wr_slot;
  logic [ENTITY_W-1:0] wr_data;
  logic wr_ready;
  logic commit;
  logic clear;
  logic commit_pending;
  logic frame_tick;
  modport master (
    output wr_valid, wr_slot, wr_data, commit, clear,
    input wr_ready, commit_pending, frame_tick
  );
  modport slave (
    input wr_valid, wr_slot, wr_data, commit, clear,
    output wr_ready, commit_pending, frame_tick
  );
endinterface

// File: rtl/entity_frame_buffer_frame_edge_detect.sv
// frame_edge_detect: registers counter_V and flags the first cycle it reads V_SWAP (clk_in, reset, counter_V -> vblank_start)
module frame_edge_detect
  import entity_frame_buffer_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic [9:0] counter_V,
  output logic       vblank_start
);
  logic [9:0] prev_V;
  always_ff @(posedge clk_in) prev_V <= reset ? 10'd0 : counter_V;
  assign vblank_start = (counter_V == V_SWAP) && (prev_V != V_SWAP);
endmodule

// File: rtl/entity_frame_buffer.sv
// entity_frame_buffer: double-buffered entity slots, back buffer written via bus, copied to entities_out at vblank start (clk_in, reset, counter_V, bus, entities_out)
module entity_frame_buffer
  import entity_frame_buffer_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [9:0]           counter_V,
  entity_frame_buffer_if.slave bus,
  output logic [OUT_W-1:0]     entities_out
);
  state_t state, nxt;
  logic [ENTITY_W-1:0] back [NUM_SLOTS];
  logic [ENTITY_W-1:0] front [NUM_SLOTS];
  logic [3:0] clr_idx;
  logic vblank_start, clr_last, frame_tick;
  frame_edge_detect u_edge (
    .clk_in(clk_in),
    .reset(reset),
    .counter_V(counter_V),
    .vblank_start(vblank_start)
  );
  assign clr_last = clr_idx == 4'(NUM_SLOTS - 1);
  always_comb begin
    nxt = state;
    nxt = state == ACCEPT ? (bus.clear ? CLEAR : bus.commit ? WAIT : ACCEPT) :
          state == CLEAR  ? (clr_last ? ACCEPT : CLEAR) :
          state == WAIT   ? (vblank_start ? ACCEPT : WAIT) : ACCEPT;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= ACCEPT;
      clr_idx <= 4'd0;
      frame_tick <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        back[i] <= EMPTY;
        front[i] <= EMPTY;
      end
    end else begin
      state <= nxt;
      frame_tick <= state == WAIT && vblank_start;
      if (state == ACCEPT && bus.wr_valid && bus.wr_slot < 4'(NUM_SLOTS))
        back[bus.wr_slot] <= bus.wr_data;
      if (state == CLEAR) begin
        back[clr_idx] <= EMPTY;
        clr_idx <= clr_last ? 4'd0 : clr_idx + 4'd1;
      end
      if (state == WAIT && vblank_start)
        front <= back;
    end
  end
  assign bus.wr_ready = state == ACCEPT;
  assign bus.commit_pending = state == WAIT;
  assign bus.frame_tick = frame_tick;
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
    assign entities_out[g*ENTITY_W +: ENTITY_W] = front[g];
  end
endmodule

// File: tb/tb_entity_frame_buffer.sv
// tb_entity_frame_buffer: directed vectors with hand-computed expectations for entity_frame_buffer
module tb_entity_frame_buffer;
  import entity_frame_buffer_pkg::*;
  logic clk_in = 1'b0;
  logic reset;
  logic [9:0] counter_V;
  logic [OUT_W-1:0] entities_out;
  logic [OUT_W-1:0] all_empty, exp_vec;
  int checks = 0;
  int errors = 0;
  int tick_cnt, swap_v, low_cnt, pend_seen;
  entity_frame_buffer_if bus ();
  entity_frame_buffer dut (
    .clk_in(clk_in),
    .reset(reset),
    .counter_V(counter_V),
    .bus(bus),
    .entities_out(entities_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  function automatic logic [ENTITY_W-1:0] slot(input int n);
    return entities_out[n*ENTITY_W +: ENTITY_W];
  endfunction
  function automatic logic [OUT_W-1:0] with_slot(input logic [OUT_W-1:0] v, input int n, input logic [ENTITY_W-1:0] d);
    logic [OUT_W-1:0] r;
    r = v;
    r[n*ENTITY_W +: ENTITY_W] = d;
    return r;
  endfunction
  task automatic run_lines(input int a, input int b);
    for (int v = a; v <= b; v++) begin
      counter_V = 10'(v);
      tick();
      if (bus.frame_tick) begin
        tick_cnt++;
        swap_v = v;
      end
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    counter_V = 10'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic wr(input logic [3:0] s, input logic [ENTITY_W-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_slot = s;
    bus.wr_data = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask
  task automatic pulse_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < NUM_SLOTS; i++) all_empty[i*ENTITY_W +: ENTITY_W] = 20'hF0000;
    bus.wr_valid = 1'b0;
    bus.wr_slot = 4'd0;
    bus.wr_data = '0;
    bus.commit = 1'b0;
    bus.clear = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("reset_front", entities_out, all_empty);
    chk("reset_wr_ready", OUT_W'(bus.wr_ready), OUT_W'(1));
    chk("reset_frame_tick", OUT_W'(bus.frame_tick), OUT_W'(0));
    chk("reset_pending", OUT_W'(bus.commit_pending), OUT_W'(0));
    wr(4'd3, 20'h2A5A0);
    pulse_commit();
    chk("t2_pending", OUT_W'(bus.commit_pending), OUT_W'(1));
    chk("t2_wr_ready_wait", OUT_W'(bus.wr_ready), OUT_W'(0));
    tick_cnt = 0;
    swap_v = -1;
    run_lines(0, 479);
    chk("t2_slot3_before", OUT_W'(slot(3)), OUT_W'(20'hF0000));
    chk("t2_pending_before", OUT_W'(bus.commit_pending), OUT_W'(1));
    run_lines(480, 480);
    chk("t2_slot3_after", OUT_W'(slot(3)), OUT_W'(20'h2A5A0));
    chk("t2_frame_tick", OUT_W'(bus.frame_tick), OUT_W'(1));
    chk("t2_pending_after", OUT_W'(bus.commit_pending), OUT_W'(0));
    run_lines(481, 524);
    chk("t2_tick_count", OUT_W'(tick_cnt), OUT_W'(1));
    chk("t2_swap_line", OUT_W'(swap_v), OUT_W'(480));
    do_reset();
    wr(4'd3, 20'h2A5A0);
    tick_cnt = 0;
    run_lines(0, 524);
    run_lines(0, 524);
    chk("t3_front_unchanged", entities_out, all_empty);
    chk("t3_no_tick", OUT_W'(tick_cnt), OUT_W'(0));
    counter_V = 10'd0;
    bus.commit = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.commit = 1'b0;
    bus.clear = 1'b0;
    low_cnt = 0;
    pend_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.wr_ready) low_cnt++;
      if (bus.commit_pending) pend_seen++;
      tick();
    end
    chk("t4_clear_cycles", OUT_W'(low_cnt), OUT_W'(15));
    chk("t4_no_pending", OUT_W'(pend_seen), OUT_W'(0));
    pulse_commit();
    tick_cnt = 0;
    run_lines(0, 524);
    chk("t4_back_cleared", entities_out, all_empty);
    chk("t4_tick", OUT_W'(tick_cnt), OUT_W'(1));
    wr(4'd2, 20'h4B3C1);
    tick_cnt = 0;
    run_lines(0, 480);
    counter_V = 10'd481;
    pulse_commit();
    bus.wr_valid = 1'b1;
    bus.wr_slot = 4'd5;
    bus.wr_data = 20'h11111;
    run_lines(482, 524);
    run_lines(0, 479);
    chk("t5_no_early_swap", entities_out, all_empty);
    chk("t5_still_pending", OUT_W'(bus.commit_pending), OUT_W'(1));
    bus.wr_valid = 1'b0;
    run_lines(480, 524);
    exp_vec = with_slot(all_empty, 2, 20'h4B3C1);
    chk("t5_late_swap", entities_out, exp_vec);
    chk("t5_tick_count", OUT_W'(tick_cnt), OUT_W'(1));
    chk("t5_swap_line", OUT_W'(swap_v), OUT_W'(480));
    wr(4'd15, 20'h12345);
    chk("t6_oob_ready", OUT_W'(bus.wr_ready), OUT_W'(1));
    pulse_commit();
    tick_cnt = 0;
    run_lines(0, 524);
    chk("t6_oob_discarded", entities_out, exp_vec);
    chk("t6_tick", OUT_W'(tick_cnt), OUT_W'(1));
    pulse_commit();
    run_lines(0, 100);
    reset = 1'b1;
    tick();
    chk("t6_reset_front", entities_out, all_empty);
    chk("t6_reset_pending", OUT_W'(bus.commit_pending), OUT_W'(0));
    reset = 1'b0;
    tick_cnt = 0;
    run_lines(101, 524);
    chk("t6_commit_lost", OUT_W'(tick_cnt), OUT_W'(0));
    chk("t6_ready_after", OUT_W'(bus.wr_ready), OUT_W'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
